// File: rtl/vr_pkg.sv
// Shared defaults and sizing helpers for the valid/ready FIFO.
package vr_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 4;

  // Occupancy runs 0..DEPTH inclusive, hence the +1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_DEPTH);
endpackage

// File: rtl/vr_fifo_mem.sv
// FIFO storage: registered write port, asynchronous read port, no reset.
module vr_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AW         = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/vr_fifo.sv
// First-word fall-through valid/ready FIFO; every flag and count is registered,
// so no input reaches an output combinationally.
module vr_fifo
  import vr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_THRESH  = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         almost_full
);
  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push, pop;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count       <= count_nxt;
      // Flags track the next occupancy so they line up with count.
      in_ready    <= count_nxt < DEPTH_C;
      out_valid   <= count_nxt != '0;
      almost_full <= count_nxt >= AF_C;
    end
  end

  vr_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (out_data)
  );
endmodule

// File: tb/tb_vr_fifo.sv
// Directed and randomized-stall checks for vr_fifo at depths 4 and 3.
module tb_vr_fifo;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, almost_full;
  logic [31:0] in_data, out_data;
  logic [2:0]  count;

  logic        i3_valid, i3_ready, o3_valid, o3_ready, af3;
  logic [31:0] i3_data, o3_data;
  logic [1:0]  count3;

  vr_fifo #(.DATA_WIDTH(32), .DEPTH(4), .AF_THRESH(3)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .almost_full(almost_full)
  );

  vr_fifo #(.DATA_WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(i3_valid), .in_ready(i3_ready), .in_data(i3_data),
    .out_valid(o3_valid), .out_ready(o3_ready), .out_data(o3_data),
    .count(count3), .almost_full(af3)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input int cnt, input logic af,
                           input logic ir, input logic ov);
    check({tag, "_count"}, 32'(count), cnt);
    check({tag, "_af"},    32'(almost_full), 32'(af));
    check({tag, "_ir"},    32'(in_ready), 32'(ir));
    check({tag, "_ov"},    32'(out_valid), 32'(ov));
  endtask

  logic [31:0] push_vals [4];
  int          q[$];
  int          nxt, got, cyc, exp_v;
  logic        stall;
  logic [31:0] held;

  initial begin
    push_vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    i3_valid = 1'b0; i3_data = '0; o3_ready = 1'b0;

    // Reset state, then in_ready rises one cycle after rst drops
    tick(); tick();
    chk_flags("rst", 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_flags("post_rst", 0, 1'b0, 1'b1, 1'b0);

    // Fall-through latency of a single push
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    check("fwft_same_cycle_ov", 32'(out_valid), 0);
    tick();
    in_valid = 1'b0;
    chk_flags("fwft", 1, 1'b0, 1'b1, 1'b1);
    check("fwft_data", out_data, 32'hDEADBEEF);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_flags("fwft_drain", 0, 1'b0, 1'b1, 1'b0);

    // Out_ready ignored while empty
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_flags("empty_pop", 0, 1'b0, 1'b1, 1'b0);

    // Fill to full; almost_full from count=3
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = push_vals[i];
      tick();
      chk_flags($sformatf("fill%0d", i), i + 1, (i + 1) >= 3, (i + 1) < 4, 1'b1);
    end
    in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    chk_flags("full_offer", 4, 1'b1, 1'b0, 1'b1);
    check("full_head", out_data, 32'h11);

    // Pop one from full: in_ready rises only after the edge
    out_ready = 1'b1;
    check("pop_head", out_data, 32'h11);
    check("pop_ir_same", 32'(in_ready), 0);
    tick();
    out_ready = 1'b0;
    chk_flags("pop_full", 3, 1'b1, 1'b1, 1'b1);
    check("pop_next", out_data, 32'h22);

    // Drain; 0x55 must not appear
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check($sformatf("drain%0d", i), out_data, push_vals[i]);
      tick();
    end
    out_ready = 1'b0;
    chk_flags("drained", 0, 1'b0, 1'b1, 1'b0);

    // Streaming: one transfer per cycle, count steady at 1
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = i;
      tick();
      check($sformatf("stream_data%0d", i), out_data, i);
      check($sformatf("stream_cnt%0d", i), 32'(count), 1);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk_flags("stream_end", 0, 1'b0, 1'b1, 1'b0);

    // Mid-operation reset discards contents
    in_valid = 1'b1; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_flags("mid_rst", 0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_flags("mid_rst_after", 0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 32'hAA;
    tick();
    in_valid = 1'b0;
    check("rst_first_ov", 32'(out_valid), 1);
    check("rst_first_data", out_data, 32'hAA);
    check("rst_first_cnt", 32'(count), 1);

    // Random stalls on the depth-3 instance against a queue scoreboard
    nxt = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      i3_valid = ($urandom_range(0, 3) != 0);
      i3_data  = nxt;
      o3_ready = ($urandom_range(0, 2) != 0);
      if (o3_valid && o3_ready) begin
        if (q.size() == 0) begin
          check("rnd_underflow", 32'(o3_valid), 0);
        end else begin
          exp_v = q.pop_front();
          check("rnd_data", o3_data, exp_v);
        end
        got++;
      end
      if (i3_valid && i3_ready) begin
        q.push_back(nxt);
        nxt++;
      end
      stall = o3_valid && !o3_ready;
      held  = o3_data;
      tick();
      cyc++;
      if (stall) begin
        check("stall_ov", 32'(o3_valid), 1);
        check("stall_data", o3_data, held);
      end
      check("rnd_count", 32'(count3), q.size());
      check("rnd_ir", 32'(i3_ready), 32'(q.size() < 3));
    end
    i3_valid = 1'b0; o3_ready = 1'b0;
    check("rnd_done", got, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
